mc_test_sequencer: RTL and testbench



---
 rtl/mc_test_sequencer_if.sv | 26 ++
 rtl/mc_test_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_mc_test_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_test_sequencer_if.sv
// Avalon-MM slave bundle between the HPS bridge and the multicycle test
// sequencer. The bridge side uses the master modport and the sequencer uses
// the slave modport.
interface mc_test_sequencer_if;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/mc_test_sequencer.sv
// Multicycle test sequencer for the MSDF adder path. It launches LFSR operand
// pairs at a programmable spacing and samples the datapath result a
// programmable number of cycles after each launch. The samples fold into a
// rotate-xor checksum. Every output is driven from a flop, so launch and the
// operands are predicted one cycle ahead from the next-state logic.
module mc_test_sequencer #(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 16,
  parameter int MAX_LAT = 15
) (
  input  logic               pll_clock,
  input  logic               reset_n,
  mc_test_sequencer_if.slave avs,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               launch,
  input  logic [WIDTH-1:0]   result_in,
  output logic               busy,
  output logic               done_irq
);

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Galois LFSR step: shift right, fold in the polynomial when bit 0 leaves
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] fb;
    fb = s[0] ? LFSR_POLY : 32'h0000_0000;
    return (s >> 1) ^ fb;
  endfunction

  // Full 32-bit bit reversal used to derive operand B
  function automatic logic [31:0] bit_rev32(input logic [31:0] s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = s[31-i];
    end
    return r;
  endfunction

  // Rotate left by one for the checksum fold
  function automatic logic [31:0] rotl1(input logic [31:0] c);
    return {c[30:0], c[31]};
  endfunction

  // Configuration registers (raw values as written)
  logic [CNT_W-1:0]   count_r;
  logic [3:0]         latency_r;
  logic [3:0]         spacing_r;
  logic [31:0]        seed_r;

  // Run state
  state_e             state_r, state_nxt_s;
  logic [3:0]         spc_r, spc_nxt_s;
  logic [CNT_W-1:0]   issued_r, issued_nxt_s;
  logic [CNT_W-1:0]   captured_r, captured_nxt_s;
  logic [31:0]        checksum_r, checksum_nxt_s;
  logic [MAX_LAT-1:0] tag_r, tag_nxt_s;
  logic [31:0]        lfsr_r, lfsr_base_s, rev_s;
  logic               launch_r, launch_nxt_s;
  logic [WIDTH-1:0]   op_a_r, op_b_r;
  logic               busy_r, done_irq_r, done_nxt_s;
  logic [31:0]        readdata_r, rd_mux_s;

  // Bus decode and sanitised settings
  logic               wr_ctrl_s, start_req_s, clr_req_s, cfg_wr_s, sample_s;
  logic [3:0]         lat_eff_s, spc_eff_s, tap_s;
  logic [31:0]        seed_eff_s;

  assign op_a             = op_a_r;
  assign op_b             = op_b_r;
  assign launch           = launch_r;
  assign busy             = busy_r;
  assign done_irq         = done_irq_r;
  assign avs.avs_readdata = readdata_r;

  assign wr_ctrl_s   = avs.avs_write && (avs.avs_address == 3'd0);
  assign start_req_s = wr_ctrl_s && avs.avs_writedata[0];
  assign clr_req_s   = wr_ctrl_s && avs.avs_writedata[1];
  assign cfg_wr_s    = avs.avs_write && !busy_r;
  assign rev_s       = bit_rev32(lfsr_base_s);

  // Zero settings are treated as one; latency is clamped to the tag pipe depth
  always_comb begin
    lat_eff_s  = (latency_r == 4'd0) ? 4'd1 : latency_r;
    spc_eff_s  = (spacing_r == 4'd0) ? 4'd1 : spacing_r;
    seed_eff_s = (seed_r == 32'd0) ? 32'd1 : seed_r;
    if (lat_eff_s > 4'(MAX_LAT)) begin
      tap_s = 4'(MAX_LAT - 1);
    end else begin
      tap_s = lat_eff_s - 4'd1;
    end
  end

  // A tag at tap_s marks the cycle exactly LATENCY cycles after its launch
  assign sample_s = tag_r[tap_s] && ((state_r == ST_ISSUE) || (state_r == ST_DRAIN));

  // Configuration register writes, frozen while a run is in progress
  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r   <= '0;
      latency_r <= 4'd1;
      spacing_r <= 4'd2;
      seed_r    <= 32'd1;
    end else if (cfg_wr_s) begin
      case (avs.avs_address)
        3'd2:    count_r   <= avs.avs_writedata[CNT_W-1:0];
        3'd3:    latency_r <= avs.avs_writedata[3:0];
        3'd4:    spacing_r <= avs.avs_writedata[3:0];
        3'd5:    seed_r    <= avs.avs_writedata;
        default: ;
      endcase
    end
  end

  // Next-state logic: sequencing, launch prediction, capture fold
  always_comb begin
    state_nxt_s    = state_r;
    spc_nxt_s      = spc_r;
    issued_nxt_s   = issued_r;
    captured_nxt_s = captured_r;
    checksum_nxt_s = checksum_r;
    tag_nxt_s      = {tag_r[MAX_LAT-2:0], launch_r};
    lfsr_base_s    = lfsr_r;

    if (sample_s) begin
      checksum_nxt_s = rotl1(checksum_r) ^ 32'(result_in);
      captured_nxt_s = captured_r + 1'b1;
    end else begin
      checksum_nxt_s = checksum_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start_req_s) begin
          lfsr_base_s    = seed_eff_s;
          checksum_nxt_s = 32'd0;
          issued_nxt_s   = '0;
          captured_nxt_s = '0;
          tag_nxt_s      = '0;
          spc_nxt_s      = 4'd0;
          state_nxt_s    = (count_r == '0) ? ST_DONE : ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (launch_r) begin
          issued_nxt_s = issued_r + 1'b1;
          spc_nxt_s    = spc_eff_s - 4'd1;
          if (issued_nxt_s == count_r) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end else begin
          spc_nxt_s = spc_r - 4'd1;
        end
      end
      ST_DRAIN: begin
        if (captured_r == count_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase

    launch_nxt_s = (state_nxt_s == ST_ISSUE) && (spc_nxt_s == 4'd0);
  end

  // done_irq: set on completion, cleared by CTRL bit1, otherwise sticky
  always_comb begin
    if (state_r == ST_DONE) begin
      done_nxt_s = 1'b1;
    end else if (clr_req_s) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_irq_r;
    end
  end

  // Run state, operand and status registers
  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      spc_r      <= 4'd0;
      issued_r   <= '0;
      captured_r <= '0;
      checksum_r <= 32'd0;
      tag_r      <= '0;
      lfsr_r     <= 32'd0;
      launch_r   <= 1'b0;
      op_a_r     <= '0;
      op_b_r     <= '0;
      busy_r     <= 1'b0;
      done_irq_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      spc_r      <= spc_nxt_s;
      issued_r   <= issued_nxt_s;
      captured_r <= captured_nxt_s;
      checksum_r <= checksum_nxt_s;
      tag_r      <= tag_nxt_s;
      launch_r   <= launch_nxt_s;
      busy_r     <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_DRAIN);
      done_irq_r <= done_nxt_s;
      if (launch_nxt_s) begin
        op_a_r <= lfsr_base_s[WIDTH-1:0];
        op_b_r <= rev_s[WIDTH-1:0];
        lfsr_r <= lfsr_step(lfsr_base_s);
      end else begin
        lfsr_r <= lfsr_base_s;
      end
    end
  end

  // Read multiplexer; unmapped bits read as zero
  always_comb begin
    case (avs.avs_address)
      3'd0:    rd_mux_s = 32'd0;
      3'd1:    rd_mux_s = {30'd0, done_irq_r, busy_r};
      3'd2:    rd_mux_s = 32'(count_r);
      3'd3:    rd_mux_s = {28'd0, latency_r};
      3'd4:    rd_mux_s = {28'd0, spacing_r};
      3'd5:    rd_mux_s = seed_r;
      3'd6:    rd_mux_s = checksum_r;
      3'd7:    rd_mux_s = {16'(captured_r), 16'(issued_r)};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Registered read data, one cycle after the read strobe
  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'd0;
    end else if (avs.avs_read) begin
      readdata_r <= rd_mux_s;
    end
  end

endmodule

// File: tb/tb_mc_test_sequencer.sv
// Self-checking bench for mc_test_sequencer: directed scenarios plus random
// runs. A loopback returns op_a delayed by the configured latency, so every
// sample sees its own launch operand. Expected operands and checksums come
// from a behavioural LFSR/checksum model.
module tb_mc_test_sequencer;
  localparam int WIDTH = 32;

  logic             pll_clock = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] op_a, op_b, result_in;
  logic             launch, busy, done_irq;

  mc_test_sequencer_if avs_bus();

  mc_test_sequencer #(.WIDTH(WIDTH), .CNT_W(16), .MAX_LAT(15)) dut (
    .pll_clock (pll_clock),
    .reset_n   (reset_n),
    .avs       (avs_bus.slave),
    .op_a      (op_a),
    .op_b      (op_b),
    .launch    (launch),
    .result_in (result_in),
    .busy      (busy),
    .done_irq  (done_irq)
  );

  always #5 pll_clock = ~pll_clock;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model of the generator and checksum rules
  function automatic logic [31:0] m_next(input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ 32'h8020_0003;
    return s >> 1;
  endfunction

  function automatic logic [31:0] m_rev(input logic [31:0] s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = s[i];
    return r;
  endfunction

  function automatic logic [31:0] m_fold(input logic [31:0] c, input logic [31:0] v);
    return ((c << 1) | (c >> 31)) ^ v;
  endfunction

  // Loopback and launch monitor, sampled on the falling edge
  logic [31:0] hist [16];
  int          cyc = 0;
  int          loop_lat = 1;
  logic [31:0] launch_a[$];
  logic [31:0] launch_b[$];
  int          launch_c[$];

  initial begin
    for (int i = 0; i < 16; i++) hist[i] = 32'd0;
    result_in = '0;
  end

  always @(negedge pll_clock) begin
    hist[cyc % 16] = op_a;
    result_in = hist[(cyc + 16 - loop_lat) % 16];
    if (launch === 1'b1) begin
      launch_a.push_back(op_a);
      launch_b.push_back(op_b);
      launch_c.push_back(cyc);
    end
    cyc++;
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge pll_clock);
    avs_bus.avs_address   = a;
    avs_bus.avs_writedata = d;
    avs_bus.avs_write     = 1'b1;
    @(negedge pll_clock);
    avs_bus.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge pll_clock);
    avs_bus.avs_address = a;
    avs_bus.avs_read    = 1'b1;
    @(negedge pll_clock);
    avs_bus.avs_read    = 1'b0;
    d = avs_bus.avs_readdata;
  endtask

  logic [31:0] exp_seed;
  int          exp_count, exp_spc;

  task automatic start_run(input logic [31:0] seed, input int cnt, input int lat, input int spc);
    exp_seed  = seed;
    exp_count = cnt;
    exp_spc   = (spc == 0) ? 1 : spc;
    loop_lat  = (lat == 0) ? 1 : lat;
    bus_write(3'd2, 32'(cnt));
    bus_write(3'd3, 32'(lat));
    bus_write(3'd4, 32'(spc));
    bus_write(3'd5, seed);
    launch_a.delete();
    launch_b.delete();
    launch_c.delete();
    bus_write(3'd0, 32'd3);
    check_val("first_launch", {31'd0, launch}, {31'd0, cnt != 0});
  endtask

  task automatic finish_run(input string name);
    int          n;
    logic [31:0] s, csum, d;
    n = 0;
    while (done_irq !== 1'b1 && n < 4000) begin
      @(negedge pll_clock);
      n++;
    end
    check_val({name, ":timeout"}, {31'd0, n < 4000}, 32'd1);
    if (exp_count == 0) check_val({name, ":zero_done_time"}, {31'd0, n <= 2}, 32'd1);
    check_val({name, ":n_launch"}, 32'(launch_a.size()), 32'(exp_count));
    s    = (exp_seed == 32'd0) ? 32'd1 : exp_seed;
    csum = 32'd0;
    for (int i = 0; i < exp_count; i++) begin
      if (i < launch_a.size()) begin
        check_val({name, ":op_a"}, launch_a[i], s);
        check_val({name, ":op_b"}, launch_b[i], m_rev(s));
      end
      csum = m_fold(csum, s);
      s    = m_next(s);
    end
    for (int i = 1; i < launch_c.size(); i++)
      check_val({name, ":gap"}, 32'(launch_c[i] - launch_c[i-1]), 32'(exp_spc));
    check_val({name, ":busy_after"}, {31'd0, busy}, 32'd0);
    bus_read(3'd6, d);
    check_val({name, ":checksum"}, d, csum);
    bus_read(3'd7, d);
    check_val({name, ":counters"}, d, {exp_count[15:0], exp_count[15:0]});
    bus_read(3'd1, d);
    check_val({name, ":status"}, d, 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] exp_rst [8];
    int          n;
    exp_rst = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd1, 32'd0, 32'd0};
    avs_bus.avs_address   = 3'd0;
    avs_bus.avs_write     = 1'b0;
    avs_bus.avs_writedata = 32'd0;
    avs_bus.avs_read      = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge pll_clock);
    reset_n = 1'b1;

    // Reset state
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_launch", {31'd0, launch}, 32'd0);
    check_val("rst_done", {31'd0, done_irq}, 32'd0);
    check_val("rst_op_a", op_a, 32'd0);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      check_val($sformatf("rst_reg%0d", a), d, exp_rst[a]);
    end
    check_val("rst_no_launch", 32'(launch_a.size()), 32'd0);

    // Reference run: spacing 2, latency 2
    start_run(32'd1, 3, 2, 2);
    finish_run("ref_s2_l2");
    check_val("ref_op_a0", launch_a[0], 32'h0000_0001);
    check_val("ref_op_a1", launch_a[1], 32'h8020_0003);
    check_val("ref_op_a2", launch_a[2], 32'hC030_0002);
    bus_read(3'd6, d);
    check_val("ref_checksum_const", d, 32'hC070_0001);

    // Back-to-back launches with launch/sample overlap
    start_run(32'd1, 3, 5, 1);
    finish_run("ref_s1_l5");
    bus_read(3'd6, d);
    check_val("s1_checksum_const", d, 32'hC070_0001);

    // COUNT = 0
    start_run(32'd1, 0, 1, 1);
    finish_run("zero_count");

    // Start and COUNT writes while busy are ignored; bit1 clears done_irq
    start_run(32'h1234_5678, 6, 4, 3);
    bus_write(3'd2, 32'd2);
    bus_write(3'd0, 32'd1);
    check_val("busy_during", {31'd0, busy}, 32'd1);
    finish_run("busy_ignore");
    bus_read(3'd2, d);
    check_val("count_kept", d, 32'd6);
    bus_write(3'd0, 32'd2);
    check_val("done_cleared", {31'd0, done_irq}, 32'd0);

    // Reset during DRAIN
    start_run(32'hDEAD_BEEF, 4, 15, 1);
    n = 0;
    while (launch_a.size() < 4 && n < 200) begin
      @(negedge pll_clock);
      n++;
    end
    check_val("drain_reached", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_launch", {31'd0, launch}, 32'd0);
    repeat (2) @(negedge pll_clock);
    reset_n = 1'b1;
    repeat (20) @(negedge pll_clock);
    check_val("mid_rst_no_launch", 32'(launch_a.size()), 32'd4);
    bus_read(3'd7, d);
    check_val("mid_rst_counters", d, 32'd0);
    bus_read(3'd6, d);
    check_val("mid_rst_checksum", d, 32'd0);
    bus_read(3'd1, d);
    check_val("mid_rst_status", d, 32'd0);
    start_run(32'hDEAD_BEEF, 4, 15, 1);
    finish_run("after_reset");

    // Randomised runs
    for (int r = 0; r < 8; r++) begin
      start_run($urandom, $urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 15));
      finish_run($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
